// File: rtl/ysyx_22041071_if_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package ysyx_22041071_if_fetch_pkg;

   localparam int unsigned   FETCH_ADDR_W   = 64;
   localparam int unsigned   FETCH_INS_W    = 32;
   localparam logic [63:0]   FETCH_RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0]   FETCH_NOP      = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/ysyx_22041071_if_fetch.sv
// Instruction-fetch stage: single-outstanding imem requests, presents PC2/Ins1 to
// decode under ready2 backpressure, and squashes wrong-path fetches on redirect.
module ysyx_22041071_if_fetch
   import ysyx_22041071_if_fetch_pkg::*;
#(
   parameter int unsigned           ADDR_W   = FETCH_ADDR_W,
   parameter int unsigned           INS_W    = FETCH_INS_W,
   parameter logic [ADDR_W-1:0]     RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              ready2,
   output logic              valid2,
   output logic [ADDR_W-1:0] PC2,
   output logic [INS_W-1:0]  Ins1,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INS_W-1:0]  imem_rdata
);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc_r;
   logic              drop_r;

   assign imem_addr = pc_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         pc_r           <= RESET_PC;
         drop_r         <= 1'b0;
         valid2         <= 1'b0;
         PC2            <= RESET_PC;
         Ins1           <= INS_W'(FETCH_NOP);
         imem_req_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (redirect_valid) pc_r <= redirect_pc;
               state          <= S_REQ;
               imem_req_valid <= 1'b1;
            end
            S_REQ: begin
               if (redirect_valid) pc_r <= redirect_pc;
               if (imem_req_ready) begin
                  // A redirect alongside acceptance makes the in-flight fetch wrong-path.
                  state          <= S_WAIT;
                  drop_r         <= redirect_valid;
                  imem_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  drop_r <= 1'b0;
                  if (drop_r || redirect_valid) begin
                     if (redirect_valid) pc_r <= redirect_pc;
                     state          <= S_REQ;
                     imem_req_valid <= 1'b1;
                  end else begin
                     Ins1   <= imem_rdata;
                     PC2    <= pc_r;
                     valid2 <= 1'b1;
                     pc_r   <= pc_r + ADDR_W'(4);
                     state  <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  drop_r <= 1'b1;
                  pc_r   <= redirect_pc;
               end
            end
            S_HOLD: begin
               // A redirect with the handshake means the held instruction is the jump itself.
               if (redirect_valid || ready2) begin
                  if (redirect_valid) pc_r <= redirect_pc;
                  valid2         <= 1'b0;
                  state          <= S_REQ;
                  imem_req_valid <= 1'b1;
               end
            end
         endcase
      end
   end

   rsp_only_in_wait: assert property (@(posedge clk) disable iff (reset)
      imem_rsp_valid |-> state == S_WAIT);

   valid2_held: assert property (@(posedge clk) disable iff (reset)
      (valid2 && !ready2 && !redirect_valid) |=> valid2);

endmodule

// File: tb/tb_ysyx_22041071_if_fetch.sv
// Directed bench for the fetch stage: an imem responder, a handshake scoreboard,
// and direct checks of reset, backpressure, redirect and PC wrap behaviour.
module tb_ysyx_22041071_if_fetch;

   localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        ready2;
   logic        valid2;
   logic [63:0] PC2;
   logic [31:0] Ins1;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] ins;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned mem_lat     = 1;

   ysyx_22041071_if_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ready2         (ready2),
      .valid2         (valid2),
      .PC2            (PC2),
      .Ins1           (Ins1),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memfn(input logic [63:0] a);
      if (a == 64'h0000_0000_8000_0000) return 32'h0000_0093;
      return a[31:0] ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid2(input string name);
      for (int i = 0; i < 20; i++) begin
         if (valid2) return;
         tick();
      end
      chk({name, "_timeout"}, 64'(valid2), 64'd1);
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid) return;
         tick();
      end
      chk({name, "_timeout"}, 64'(imem_req_valid), 64'd1);
   endtask

   // imem responder: accepts when req_valid&ready, answers mem_lat cycles later.
   initial begin
      int unsigned cnt;
      logic [63:0] maddr;
      cnt            = 0;
      maddr          = '0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
      forever begin
         tick();
         if (reset) begin
            cnt            = 0;
            imem_rsp_valid = 1'b0;
         end else begin
            imem_rsp_valid = 1'b0;
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  imem_rsp_valid = 1'b1;
                  imem_rdata     = memfn(maddr);
               end
            end
            if (imem_req_valid && imem_req_ready) begin
               cnt   = mem_lat;
               maddr = imem_addr;
            end
         end
      end
   end

   // Scoreboard monitor: every decode handshake must match the next expected fetch.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && valid2 && ready2) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_handshake_pc", PC2, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc2", PC2, e.pc);
               chk("sb_ins1", 64'(Ins1), 64'(e.ins));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] hold_pc;
      logic [31:0] hold_ins;
      int unsigned seen;

      reset          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ready2         = 1'b1;
      #1 reset = 1'b1;
      tick();
      tick();
      chk("rst_valid2", 64'(valid2), 64'd0);
      chk("rst_pc2", PC2, RST_PC);
      chk("rst_ins1", 64'(Ins1), 64'(NOP));
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_addr", imem_addr, RST_PC);

      // First fetch after reset release
      exp_q.push_back('{pc: RST_PC, ins: 32'h0000_0093});
      reset = 1'b0;
      wait_req("t1_req");
      chk("t1_addr", imem_addr, RST_PC);
      wait_valid2("t1_valid");
      chk("t1_pc2", PC2, RST_PC);
      chk("t1_ins1", 64'(Ins1), 64'h93);
      tick();
      wait_req("t1_req2");
      chk("t1_next_addr", imem_addr, 64'h8000_0004);

      // Backpressure in HOLD
      ready2 = 1'b0;
      exp_q.push_back('{pc: 64'h8000_0004, ins: memfn(64'h8000_0004)});
      wait_valid2("t2_valid");
      hold_pc  = PC2;
      hold_ins = Ins1;
      chk("t2_pc2", hold_pc, 64'h8000_0004);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_hold_valid2", 64'(valid2), 64'd1);
         chk("t2_hold_pc2", PC2, hold_pc);
         chk("t2_hold_ins1", 64'(Ins1), 64'(hold_ins));
         chk("t2_hold_noreq", 64'(imem_req_valid), 64'd0);
      end
      ready2 = 1'b1;
      tick();
      chk("t2_req_after", 64'(imem_req_valid), 64'd1);
      chk("t2_addr_after", imem_addr, 64'h8000_0008);
      ready2 = 1'b0;

      // Redirect coinciding with handshake at 0x80000008
      exp_q.push_back('{pc: 64'h8000_0008, ins: memfn(64'h8000_0008)});
      wait_valid2("t4_valid");
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0100;
      ready2         = 1'b1;
      mem_lat        = 3;
      tick();
      redirect_valid = 1'b0;
      ready2         = 1'b0;
      chk("t4_valid2_low", 64'(valid2), 64'd0);
      chk("t4_req", 64'(imem_req_valid), 64'd1);
      chk("t4_addr", imem_addr, 64'h8000_0100);

      // Redirect while waiting for the response
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0200;
      tick();
      redirect_valid = 1'b0;
      mem_lat        = 1;
      seen           = 0;
      for (int i = 0; i < 12; i++) begin
         if (imem_req_valid) break;
         if (valid2) seen++;
         tick();
      end
      chk("t3_valid2_never", 64'(seen), 64'd0);
      chk("t3_req", 64'(imem_req_valid), 64'd1);
      chk("t3_addr", imem_addr, 64'h8000_0200);

      // Redirect in HOLD without handshake: held instruction is squashed
      wait_valid2("t5_valid");
      chk("t5_pc2", PC2, 64'h8000_0200);
      chk("t5_ins1", 64'(Ins1), 64'(memfn(64'h8000_0200)));
      redirect_valid = 1'b1;
      redirect_pc    = 64'h8000_0300;
      tick();
      redirect_valid = 1'b0;
      chk("t5_valid2_low", 64'(valid2), 64'd0);
      chk("t5_req", 64'(imem_req_valid), 64'd1);
      chk("t5_addr", imem_addr, 64'h8000_0300);
      exp_q.push_back('{pc: 64'h8000_0300, ins: memfn(64'h8000_0300)});
      ready2 = 1'b1;
      wait_valid2("t5_valid_new");
      mem_lat = 3;
      tick();
      ready2 = 1'b0;

      // Async reset mid-WAIT, outputs respond without a clock edge
      tick();
      chk("t6_pre_pc2", PC2, 64'h8000_0300);
      #2 reset = 1'b1;
      #1;
      chk("t6_async_valid2", 64'(valid2), 64'd0);
      chk("t6_async_pc2", PC2, RST_PC);
      chk("t6_async_ins1", 64'(Ins1), 64'(NOP));
      chk("t6_async_addr", imem_addr, RST_PC);
      tick();
      tick();

      // Redirect in IDLE to the top of the address space, then wrap
      exp_q.push_back('{pc: 64'hFFFF_FFFF_FFFF_FFFC, ins: memfn(64'hFFFF_FFFF_FFFF_FFFC)});
      mem_lat        = 1;
      ready2         = 1'b1;
      reset          = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      wait_req("t6_req");
      chk("t6_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_valid2("t6_valid");
      chk("t6_top_pc2", PC2, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      wait_req("t6_req_wrap");
      chk("t6_wrap_addr", imem_addr, 64'h0);
      ready2 = 1'b0;
      tick();
      tick();
      chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
